dilithium_input_packer: RTL
===========================

DILITHIUM_INPUT_PACKER -- requirements
Module: dilithium_input_packer

Interface
REQ-001 Parameter IN_W, default 32: host-side word width in bits.
REQ-002 Parameter OUT_W, default 2*IN_W (64): core-side word width; only OUT_W == 2*IN_W is supported.
REQ-003 Parameter CNT_W, default 16: width of the emitted-word counter.
REQ-004 clk  input  1  single clock; all logic is on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 clear  input  1  synchronous flush; discards the partial word, output word and count.
REQ-007 valid_i  input  1  host word valid.
REQ-008 ready_i  output  1  packer can accept a host word this cycle.
REQ-009 data_i  input  IN_W  host word.
REQ-010 last_i  input  1  host word is the final word of the message.
REQ-011 valid_o  output  1  packed word valid toward the core's data_i.
REQ-012 ready_o  input  1  core accepts the packed word (the core's ready_i).
REQ-013 data_o  output  OUT_W  packed word.
REQ-014 last_o  output  1  packed word is the final word of the message.
REQ-015 count_o  output  CNT_W  number of packed words accepted by the core since reset/clear.

Function
REQ-016 Host transfer occurs when valid_i && ready_i; core transfer occurs when valid_o && ready_o.
REQ-017 Internal state: low-half register lo_q, flag have_lo, output register {data_o, last_o}, valid_o register.
REQ-018 ready_i SHALL be !valid_o || ready_o, registered-free (combinational from state and ready_o), never dependent on valid_i, data_i or last_i.
REQ-019 Packing is little-endian: the first host word of a pair occupies data_o[IN_W-1:0], the second data_o[OUT_W-1:IN_W].
REQ-020 Host transfer with !have_lo && !last_i: data_i is stored in lo_q, have_lo set; no output produced.
REQ-021 Host transfer with have_lo: output register loads {data_i, lo_q} with last_o = last_i, valid_o set next cycle, have_lo cleared.
REQ-022 Host transfer with !have_lo && last_i: output loads {IN_W'b0, data_i}, last_o = 1 (zero-padded upper half).
REQ-023 Latency: a completed pair is visible on valid_o/data_o exactly 1 cycle after the accepting host transfer.
REQ-024 Sustained throughput: with ready_o held high, one host word is accepted every cycle and one packed word is emitted every 2 cycles.
REQ-025 Simultaneous core transfer and output load in one cycle: output register takes the new word, valid_o remains 1, no bubble.
REQ-026 Core transfer with no new output load: valid_o clears next cycle; data_o and last_o hold their value.
REQ-027 While valid_o && !ready_o: data_o, last_o and valid_o SHALL remain stable; ready_i is 0.
REQ-028 count_o increments by 1 on every core transfer and wraps from 2^CNT_W-1 to 0.
REQ-029 last_o is meaningful only while valid_o is 1.
REQ-030 clear has priority over every transfer in the same cycle: the host word and the core transfer of that cycle are dropped and not counted.

Reset
REQ-031 On rst (or clear) the next cycle SHALL show valid_o=0, data_o=0, last_o=0, have_lo=0, lo_q=0, count_o=0, ready_i=1.
REQ-032 rst mid-message discards any partial or pending word; no stale word is emitted after reset is released.
REQ-033 rst overrides clear; both behave identically apart from priority.

Verification
REQ-034 Four host words 0x11111111, 0x22222222, 0x33333333, 0x44444444 (last on 4th), ready_o=1 -> data_o 0x2222222211111111 (last_o=0), then 0x4444444433333333 (last_o=1), count_o=2.
REQ-035 Three host words A, B, C (last on C) -> data_o {B,A} then {0x00000000,C} with last_o=1.
REQ-036 Output pending, ready_o=0 for 5 cycles -> ready_i=0, data_o stable for all 5 cycles; on ready_o=1, word transfers and count_o increments by 1.
REQ-037 Continuous valid_i, ready_o=1, 8 words -> 8 host transfers in 8 consecutive cycles, 4 packed words, no lost or duplicated word.
REQ-038 rst asserted while have_lo=1 and valid_o=1 -> next cycle valid_o=0, count_o=0; following pair packs correctly from the low half.
REQ-039 count_o preloaded near wrap (CNT_W=4, 17 core transfers) -> count_o reads 1.

Source files
------------

// File: rtl/dilithium_input_packer.sv
// Packs pairs of host words into double-width core words, little-endian, with
// zero padding of an odd final word and a wrapping count of delivered words.
module dilithium_input_packer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 2*IN_W,  // only 2*IN_W is meaningful
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid_i,
  output logic             ready_i,
  input  logic [IN_W-1:0]  data_i,
  input  logic             last_i,
  output logic             valid_o,
  input  logic             ready_o,
  output logic [OUT_W-1:0] data_o,
  output logic             last_o,
  output logic [CNT_W-1:0] count_o
);

  logic [IN_W-1:0] lo_r;
  logic            have_lo_r;
  logic            host_xfer_s;
  logic            core_xfer_s;
  logic            load_s;

  // Handshake decode; ready_i depends only on state and ready_o.
  always_comb begin
    ready_i     = !valid_o || ready_o;
    host_xfer_s = valid_i && ready_i;
    core_xfer_s = valid_o && ready_o;
    load_s      = host_xfer_s && (have_lo_r || last_i);
  end

  // Pairing datapath, output register and delivered-word counter.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lo_r      <= '0;
      have_lo_r <= 1'b0;
      data_o    <= '0;
      last_o    <= 1'b0;
      valid_o   <= 1'b0;
      count_o   <= '0;
    end else begin
      if (host_xfer_s) begin
        if (have_lo_r) begin
          data_o    <= {data_i, lo_r};
          last_o    <= last_i;
          have_lo_r <= 1'b0;
        end else if (last_i) begin
          data_o <= {{IN_W{1'b0}}, data_i};
          last_o <= 1'b1;
        end else begin
          lo_r      <= data_i;
          have_lo_r <= 1'b1;
        end
      end
      // A new load wins over a departing word so back-to-back output has no bubble.
      if (load_s) begin
        valid_o <= 1'b1;
      end else if (core_xfer_s) begin
        valid_o <= 1'b0;
      end
      if (core_xfer_s) begin
        count_o <= count_o + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
